// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Executes one RV32I load or store per accepted start. The request is checked
// for legality on the accepting edge. Legal accesses drive a held memory
// request until it is acknowledged or times out. Illegal ones complete
// straight away with an error.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-low reset
//   start_i        one-cycle request from the control FSM
//   is_store_i     1 = store, 0 = load
//   funct3_i       RV32I width/sign code
//   addr_i         byte address
//   store_data_i   rs2 value for stores
//   mem_req_o      memory request, held until the ack cycle
//   mem_we_o       write strobe (stores only)
//   mem_addr_o     word-aligned address
//   mem_be_o       byte enables
//   mem_wdata_o    lane-replicated write data
//   mem_ack_i      memory completion; read data valid with it
//   mem_rdata_i    read word
//   busy_o         high whenever not idle
//   done_o         one-cycle completion pulse
//   err_o          valid with done: misaligned, illegal funct3 or timeout
//   load_data_o    sign/zero-extended load result register
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] load_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] load_data_q;

    logic        reject_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_ext_d;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

    // Decode of the incoming request. Only used on the accepting edge, so
    // everything driven afterwards comes from registered copies.
    always_comb begin
        reject_d = 1'b0;
        be_d     = 4'b1111;
        wdata_d  = 32'h0;
        if (is_store_i) begin
            reject_d = (funct3_i > 3'd2);
        end else begin
            reject_d = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
        end
        if ((funct3_i[1:0] == 2'd1) && addr_i[0]) begin
            reject_d = 1'b1;
        end
        if ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'd0)) begin
            reject_d = 1'b1;
        end
        case (funct3_i[1:0])
            2'd0:    be_d = 4'b0001 << addr_i[1:0];
            2'd1:    be_d = 4'b0011 << addr_i[1:0];
            default: be_d = 4'b1111;
        endcase
        if (is_store_i) begin
            case (funct3_i[1:0])
                2'd0:    wdata_d = {4{store_data_i[7:0]}};
                2'd1:    wdata_d = {2{store_data_i[15:0]}};
                default: wdata_d = store_data_i;
            endcase
        end
    end

    // Shift the addressed lane down to bit 0, then extend by the captured
    // funct3. A word access is always aligned, so the shifted word is the
    // read word unchanged.
    always_comb begin
        lane = mem_rdata_i >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'd0:    load_ext_d = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_ext_d = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_ext_d = {24'h0, lane[7:0]};
            3'd5:    load_ext_d = {16'h0, lane[15:0]};
            default: load_ext_d = lane;
        endcase
    end

    // Controller with registered outputs. done/err default low so they pulse
    // only in the DONE cycle. The memory bus returns to all-zero whenever no
    // request is outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        addr_lo_q  <= addr_i[1:0];
                        cnt_q      <= 8'd0;
                        if (reject_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i || (cnt_q == LastCnt)) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        err_q       <= !mem_ack_i;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_be_q    <= 4'h0;
                        mem_wdata_q <= 32'h0;
                        if (mem_ack_i && !is_store_q) begin
                            load_data_q <= load_ext_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign load_data_o = load_data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max REQ cycles without mem_ack before abort (range 2..255).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge.
- start  in  1  one-cycle request from control FSM (memory phase).
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address (ALU result).
- store_data  in  32  rs2 value.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-positioned write data.
- mem_ack  in  1  memory completion; rdata valid with it for loads.
- mem_rdata  in  32  read word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned, illegal funct3 or timeout.
- load_data  out  32  extended load result register.

Function
REQ-003 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> DONE directly on rejected request.
REQ-004 SHALL accept start only in IDLE; start in REQ/DONE ignored, no state change.
REQ-005 SHALL capture is_store, funct3, addr, store_data on the accepting edge; outputs driven only from captured values.
REQ-006 SHALL reject (err=1, no mem_req ever) when: load funct3 in {3,6,7}; store funct3 in {3..7}; half access with addr[0]=1; word access with addr[1:0]!=0.
REQ-007 SHALL assert mem_req from first REQ cycle and hold mem_req, mem_we, mem_addr, mem_be, mem_wdata stable until ack cycle inclusive.
REQ-008 SHALL treat mem_ack as meaningful only while mem_req=1; ack in first REQ cycle completes the access (minimum latency: start edge n, done in cycle n+2).
REQ-009 SHALL generate mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; same for loads and stores.
REQ-010 SHALL drive mem_wdata for stores: byte replicated x4, half replicated x2, word as-is; 0 for loads; mem_we = is_store while in REQ, else 0.
REQ-011 SHALL on load ack select lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; write load_data on ack edge.
REQ-012 SHALL hold load_data unchanged through stores, rejects, timeouts, and idle cycles.
REQ-013 SHALL keep a REQ-cycle counter, cleared on REQ entry; if TIMEOUT_CYCLES REQ cycles elapse without ack, drop mem_req on the next edge, enter DONE with err=1, and leave load_data unchanged.
REQ-014 SHALL assert done exactly one cycle (DONE state) per accepted start; err=0 in DONE unless REQ-006 or REQ-013 applies; err=0 whenever done=0.
REQ-015 SHALL ignore mem_ack when mem_req=0 (no state or data effect).

Reset
REQ-016 SHALL, when rst=0 at a rising edge, enter IDLE with mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, load_data=0, counter=0.
REQ-017 SHALL abort any in-flight access on reset without a done pulse; mem_req is low in the first cycle after the reset edge.
REQ-018 SHALL ignore start while rst=0.

Verification
REQ-019 SB addr=0x1003 data=0x000000A5, ack first REQ cycle -> mem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, we=1, done at start+2, err=0.
REQ-020 LB addr=0x2001, rdata=0x0000_80FF (byte1=0x80) -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x2002 rdata=0xBEEF0000 -> 0x0000BEEF.
REQ-021 LW addr=0x3002 -> no mem_req, done at start+1, err=1, load_data unchanged.
REQ-022 SW with ack withheld, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then done with err=1; second start during REQ ignored.
REQ-023 LW in REQ, rst=0 for one edge -> mem_req=0 next cycle, no done, load_data=0; new LW then completes normally.
REQ-024 Stray mem_ack in IDLE plus back-to-back starts (start reasserted in DONE cycle ignored, next accepted in IDLE) -> exactly one done per accepted start.
